fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction buffer between the IF stage register and the ID stage.
- Decouples IF from ID stalls: IF keeps fetching while ID is stalled, until the buffer fills.
- Each entry carries pc, instruction word, delay-slot flag and fetch exception bits.
- A controller flush empties the buffer in one cycle.

Parameters:
- DEPTH, 4: number of entries. Must be a power of 2, at least 2.
- PTR_W, 2: log2(DEPTH).
- EXC_W, ExcE_W: width of the exception vector (shared package constant).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  controller flush; discards all entries
- push_valid_i  in  1  IF presents a valid fetched instruction this cycle
- push_pc_i  in  32  pc of the pushed instruction
- push_inst_i  in  32  instruction word
- push_inslot_i  in  1  instruction is in a branch delay slot
- push_excs_i  in  EXC_W  fetch exception vector
- push_has_exc_i  in  1  any fetch exception
- full_o  in/out: out  1  no free entry; routed to the controller as the IF stall request
- pop_ready_i  in  1  ID accepts the head entry this cycle (= ~id_stall)
- pop_valid_o  out  1  head entry valid
- pop_pc_o  out  32  head pc
- pop_inst_o  out  32  head instruction word
- pop_inslot_o  out  1  head delay-slot flag
- pop_excs_o  out  EXC_W  head exception vector
- pop_has_exc_o  out  1  head exception flag
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage:
  - DEPTH-entry register array; record width 66+EXC_W bits.
  - Pointers rd_ptr and wr_ptr, each PTR_W bits, wrap modulo DEPTH.
  - Registered counter cnt, PTR_W+1 bits.
- Reset (async, rst_n=0): rd_ptr=0, wr_ptr=0, cnt=0. Array contents are don't-care.
  - All outputs read 0: pop_valid_o, pop_pc_o, pop_inst_o, pop_inslot_o, pop_excs_o, pop_has_exc_o, count_o, full_o.
- Show-ahead read: pop_* is driven combinationally from entry rd_ptr.
  - If cnt==0, every pop_* data output is forced to 0, so ID sees a NOP with no exception.
- Status signals:
  - pop_valid_o = (cnt!=0).
  - full_o = (cnt==DEPTH), combinational from cnt only.
  - count_o = cnt.
- Handshakes, evaluated at the rising edge:
  - pop  = pop_valid_o & pop_ready_i.
  - push = push_valid_i & (~full_o | pop). A push while full is accepted only if a pop happens in the same cycle.
  - push: write entry wr_ptr, then wr_ptr+1.
  - pop: rd_ptr+1.
  - cnt += push - pop.
- Latency: a push into an empty queue appears on pop_* in the next cycle. There is no same-cycle bypass.
- Dropped input: push_valid_i while full with no pop is dropped. IF must hold the instruction because full_o stalls it.
- Flush has priority over everything:
  - flush_i=1 at an edge sets rd_ptr=wr_ptr=0 and cnt=0.
  - A push or pop in the same cycle is discarded.
  - pop_valid_o=0 in the following cycle.
  - The push in the cycle after a flush is accepted normally.
- Wrap-around: pointers wrap modulo DEPTH without a bubble. Full and empty are distinguished only by cnt.
- Delay-slot integrity: records are stored and returned unmodified, and FIFO order is strict. A branch and its slot instruction are never reordered or separated except by flush.
- Reset mid-operation: the asynchronous clear takes effect immediately. Outputs go to their reset values with no clock edge required.

Decomposition:
- Shared package / defines:
  - ExcE_W and the exception bit indices, already shared with IF/ID.
  - Record field widths (FQ_PC_W=32, FQ_INST_W=32).
- Sub-module fq_ram:
  - DEPTH x width register array.
  - One synchronous write port, one asynchronous read port.
  - No reset on the data array.
- Pointer, counter and handshake logic stay in fetch_queue.

Test Plan:
- Reset with rst_n=0 mid-run (cnt=3) -> outputs drop immediately, no clock edge needed; pop_valid_o=0, count_o=0, full_o=0, pop_inst_o=0.
- Push pc 0xbfc00000/inst 0x24080001 with pop_ready_i=0 -> next cycle pop_valid_o=1, pop_pc_o=0xbfc00000, count_o=1; the following cycle with pop_ready_i=1 -> count_o=0, pop_inst_o=0.
- Push 4 entries (pc 0x0,0x4,0x8,0xc) with ID stalled -> full_o=1, count_o=4. A 5th push with no pop is dropped and count_o stays 4. Then push+pop in the same cycle -> count_o stays 4, head becomes pc 0x4.
- Continuous push+pop for 10 cycles (pointer wrap) -> pop_pc_o sequence equals the pushed sequence delayed by one cycle, no bubbles, count_o constant 1.
- Flush with count_o=3 and simultaneous push/pop -> next cycle count_o=0, pop_valid_o=0. Push pc 0xbfc00380 in the next cycle -> emerges as the head.
- Push a branch (inslot=0) then its slot (inslot=1, excs bit1=1, has_exc=1) -> popped in order with the inslot, excs and has_exc fields preserved exactly.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Constants shared between IF, the fetch queue and ID: exception vector layout and record widths.
package fetch_queue_pkg;

   // Fetch exception vector, shared with the IF and ID stages
   localparam int unsigned ExcE_W   = 4;
   localparam int unsigned ExcAdel  = 0;
   localparam int unsigned ExcRi    = 1;
   localparam int unsigned ExcIbe   = 2;
   localparam int unsigned ExcTlbl  = 3;

   localparam int unsigned FQ_PC_W   = 32;
   localparam int unsigned FQ_INST_W = 32;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch-queue storage: register array, one synchronous write port, one asynchronous read port.
module fq_ram #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2,
   parameter int unsigned WIDTH = 70
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Data array is intentionally not reset; validity is tracked by the occupancy counter
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between IF and ID with show-ahead read, single-cycle flush and
// occupancy-based full/empty detection.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2,
   parameter int unsigned EXC_W = ExcE_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic                 push_valid_i,
   input  logic [FQ_PC_W-1:0]   push_pc_i,
   input  logic [FQ_INST_W-1:0] push_inst_i,
   input  logic                 push_inslot_i,
   input  logic [EXC_W-1:0]     push_excs_i,
   input  logic                 push_has_exc_i,
   output logic                 full_o,
   input  logic                 pop_ready_i,
   output logic                 pop_valid_o,
   output logic [FQ_PC_W-1:0]   pop_pc_o,
   output logic [FQ_INST_W-1:0] pop_inst_o,
   output logic                 pop_inslot_o,
   output logic [EXC_W-1:0]     pop_excs_o,
   output logic                 pop_has_exc_o,
   output logic [PTR_W:0]       count_o
);

   localparam int unsigned RecW = FQ_PC_W + FQ_INST_W + 2 + EXC_W;
   localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             push, pop;
   logic [RecW-1:0]  wr_rec, rd_rec;

   assign pop_valid_o = (cnt_q != '0);
   assign full_o      = (cnt_q == CntFull);
   assign count_o     = cnt_q;

   assign pop  = pop_valid_o & pop_ready_i;
   // A push into a full queue is only taken when the head leaves in the same cycle
   assign push = push_valid_i & (~full_o | pop);

   assign wr_rec = {push_pc_i, push_inst_i, push_inslot_i, push_has_exc_i, push_excs_i};

   fq_ram #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .WIDTH (RecW)
   ) u_ram (
      .clk   (clk),
      .we    (push & ~flush_i),
      .waddr (wr_ptr_q),
      .wdata (wr_rec),
      .raddr (rd_ptr_q),
      .rdata (rd_rec)
   );

   // Empty queue presents an all-zero record so ID sees a NOP with no exception
   always_comb begin
      pop_pc_o      = '0;
      pop_inst_o    = '0;
      pop_inslot_o  = 1'b0;
      pop_has_exc_o = 1'b0;
      pop_excs_o    = '0;
      if (pop_valid_o) begin
         {pop_pc_o, pop_inst_o, pop_inslot_o, pop_has_exc_o, pop_excs_o} = rd_rec;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         cnt_d = cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
